// File: rtl/branch_resolver.sv
// Stage-3 branch/jump resolver: one-shot fetch redirect, FLUSH_STAGES-cycle
// squash of younger slots, and a wrapping count of taken branches/jumps.
module branch_resolver #(
  parameter int unsigned FLUSH_STAGES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             valid_i,
  input  logic             is_branch_i,
  input  logic             is_jump_i,
  input  logic [1:0]       cond_i,
  input  logic [3:0]       compare_i,
  input  logic [31:0]      target_i,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] taken_total_o
);

  localparam int unsigned CNT_BITS = 4;

  if (FLUSH_STAGES < 1 || FLUSH_STAGES > 15) begin : g_bad_flush_stages
    $error("branch_resolver: FLUSH_STAGES must be 1..15");
  end

  typedef enum logic {
    IDLE,
    SQUASH
  } state_e;

  state_e              state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                redirect_q;
  logic [31:0]         redirect_pc_q;
  logic                flush_q;
  logic                busy_q;
  logic [CNT_W-1:0]    taken_total_q;
  logic                take_c;

  // compare_i is indexed by cond_i (eq=0, ne=1, lt=2, ge=3); a jump always takes
  assign take_c = valid_i && !stall_i && (state_q == IDLE) &&
                  (is_jump_i || (is_branch_i && compare_i[cond_i]));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
      taken_total_q <= '0;
    end else if (!stall_i) begin
      case (state_q)
        IDLE: begin
          if (take_c) begin
            state_q       <= SQUASH;
            cnt_q         <= CNT_BITS'(FLUSH_STAGES - 1);
            redirect_q    <= 1'b1;
            redirect_pc_q <= target_i;
            flush_q       <= 1'b1;
            busy_q        <= 1'b1;
            taken_total_q <= taken_total_q + CNT_W'(1);
          end else begin
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        SQUASH: begin
          // wrong-path inputs are ignored until the squash window closes
          redirect_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_BITS'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          redirect_q <= 1'b0;
          flush_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign flush_o       = flush_q;
  assign busy_o        = busy_q;
  assign taken_total_o = taken_total_q;

endmodule
